// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the digit-serial adder/subtractor.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // a_s encoding
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed limit for a word of 'width' bits: most negative value when
    // 'negative' is set, most positive otherwise. Callers truncate to width.
    function automatic logic [63:0] signed_limit(input int unsigned width, input logic negative);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        signed_limit = negative ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit adder slice with carry in/out and
// the carry into its top bit (needed for signed overflow on the last digit).
module addsub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    // Sum the slice; carry into the top bit is recovered from its sum bit.
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        cmsb      = x[DIGIT-1] ^ y[DIGIT-1] ^ s[DIGIT-1];
    end

endmodule

// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial: multi-cycle two's-complement add/subtract, DIGIT bits
// per clock, LSB digit first, with C/V/Z/N flags and valid/ready handshakes.
// Optional macro ADDSUB_SATURATE_EN clamps the result to the signed limit
// on overflow.
module addsub_digit_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
`ifdef ADDSUB_SATURATE_EN
    logic             a_neg_q, a_neg_d;
`endif

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_cout;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] merged;
    logic [WIDTH-1:0]       res;
    logic [WIDTH-1:0]       fin;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .s   (dig_s),
        .cout(dig_cout),
        .cmsb(dig_cmsb)
    );

    // Next-state, operand shifting, digit accumulation and flag computation.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        sum_d       = sum_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
`ifdef ADDSUB_SATURATE_EN
        a_neg_d     = a_neg_q;
`endif
        // New digit enters at the top of the shadow; after NDIG digits the
        // first digit has walked down to bit 0.
        merged = {dig_s, shadow_q} >> DIGIT;
        res    = merged[WIDTH-1:0];
        fin    = res;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = (a_s == OP_ADD) ? b : ~b;
                    carry_d    = (a_s == OP_SUB);
                    cnt_d      = '0;
                    shadow_d   = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef ADDSUB_SATURATE_EN
                    a_neg_d    = a[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                carry_d  = dig_cout;
                shadow_d = res;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
`ifdef ADDSUB_SATURATE_EN
                    if (dig_cout ^ dig_cmsb)
                        fin = WIDTH'(signed_limit(WIDTH, a_neg_q));
`endif
                    sum_d       = fin;
                    c_d         = dig_cout;
                    v_d         = dig_cout ^ dig_cmsb;
                    z_d         = ~|fin;
                    n_d         = fin[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
            a_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            sum_q       <= sum_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
`ifdef ADDSUB_SATURATE_EN
            a_neg_q     <= a_neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_q;
    assign ovf       = v_q;
    assign zero      = z_q;
    assign neg       = n_q;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: four instances at WIDTH=16 with DIGIT of
// 4, 1, 8 and 16, checked against an arithmetic reference model.
module tb_addsub_digit_serial;

    localparam int unsigned W  = 16;
    localparam int unsigned NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [W-1:0] a         [NI];
    logic [W-1:0] b         [NI];
    logic         a_s       [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [W-1:0] sum       [NI];
    logic         c_out     [NI];
    logic         ovf       [NI];
    logic         zero      [NI];
    logic         neg       [NI];

    int errors = 0;
    int checks = 0;

    function automatic int unsigned dig_of(input int unsigned k);
        case (k)
            0: dig_of = 4;
            1: dig_of = 1;
            2: dig_of = 8;
            default: dig_of = 16;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int unsigned DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
        addsub_digit_serial #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a[g]),
            .b        (b[g]),
            .a_s      (a_s[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .sum      (sum[g]),
            .c_out    (c_out[g]),
            .ovf      (ovf[g]),
            .zero     (zero[g]),
            .neg      (neg[g])
        );
    end

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic z, output logic n);
        logic [W:0] full;
        int sa, sb, sr;
        sa = $signed(av);
        sb = $signed(bv);
        if (s) begin
            r  = av - bv;
            c  = (av >= bv);
            sr = sa - sb;
        end else begin
            full = {1'b0, av} + {1'b0, bv};
            r    = full[W-1:0];
            c    = full[W];
            sr   = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = av[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        z = (r == '0);
        n = r[W-1];
    endtask

    // One full operation on instance k: accept, wait for result, check, consume.
    task automatic run_op(input int unsigned k, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input string tag);
        logic [W-1:0] er;
        logic ec, ev, ez, en;
        int unsigned edges;
        model(av, bv, s, er, ec, ev, ez, en);
        @(negedge clk);
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready k=%0d got=%b exp=1", tag, k, in_ready[k]);
        end
        in_valid[k] = 1'b1;
        a[k] = av;
        b[k] = bv;
        a_s[k] = s;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid[k] = 1'b0;
        a[k] = 16'($urandom);
        b[k] = 16'($urandom);
        a_s[k] = 1'($urandom_range(0, 1));
        while (out_valid[k] !== 1'b1 && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges != dig_of(k) * 0 + (W / dig_of(k)) + 1) begin
            errors++;
            $display("FAIL %s latency k=%0d got=%0d exp=%0d", tag, k, edges, (W / dig_of(k)) + 1);
        end
        checks++;
        if (sum[k] !== er) begin
            errors++;
            $display("FAIL %s sum k=%0d a=%h b=%h s=%b got=%h exp=%h", tag, k, av, bv, s, sum[k], er);
        end
        checks++;
        if (c_out[k] !== ec) begin
            errors++;
            $display("FAIL %s c_out k=%0d a=%h b=%h s=%b got=%b exp=%b", tag, k, av, bv, s, c_out[k], ec);
        end
        checks++;
        if (ovf[k] !== ev) begin
            errors++;
            $display("FAIL %s ovf k=%0d a=%h b=%h s=%b got=%b exp=%b", tag, k, av, bv, s, ovf[k], ev);
        end
        checks++;
        if (zero[k] !== ez || neg[k] !== en) begin
            errors++;
            $display("FAIL %s zn k=%0d a=%h b=%h s=%b got=%b%b exp=%b%b", tag, k, av, bv, s,
                     zero[k], neg[k], ez, en);
        end
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s release k=%0d got ov=%b ir=%b exp ov=0 ir=1", tag, k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int unsigned k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            a[k] = '0;
            b[k] = '0;
            a_s[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int unsigned k = 0; k < NI; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || sum[k] !== 16'h0000 ||
                c_out[k] !== 1'b0 || ovf[k] !== 1'b0 || zero[k] !== 1'b0 || neg[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d got ir=%b ov=%b sum=%h c=%b v=%b z=%b n=%b exp ir=1 rest 0",
                         k, in_ready[k], out_valid[k], sum[k], c_out[k], ovf[k], zero[k], neg[k]);
            end
        end
    endtask

    task automatic test_directed();
        run_op(0, 16'h1234, 16'h0F0F, 1'b0, "add_basic");
        checks++;
        if (sum[0] !== 16'h2143) begin
            errors++;
            $display("FAIL add_basic_const got=%h exp=2143", sum[0]);
        end
        run_op(0, 16'h00FF, 16'h00FF, 1'b1, "sub_zero");
        run_op(0, 16'h0000, 16'h0001, 1'b1, "sub_borrow");
        run_op(0, 16'h0000, 16'h0000, 1'b1, "sub_0_0");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
        run_op(3, 16'h1234, 16'h0F0F, 1'b0, "add_full_digit");
    endtask

    task automatic test_overflow();
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
        checks++;
`ifdef ADDSUB_SATURATE_EN
        if (sum[0] !== 16'h7FFF) begin
            errors++;
            $display("FAIL ovf_pos_const got=%h exp=7fff", sum[0]);
        end
`else
        if (sum[0] !== 16'h8000) begin
            errors++;
            $display("FAIL ovf_pos_const got=%h exp=8000", sum[0]);
        end
`endif
        run_op(0, 16'h8000, 16'h0001, 1'b1, "ovf_neg_sub");
        run_op(0, 16'h8000, 16'h8000, 1'b0, "ovf_neg_add");
        run_op(0, 16'h0001, 16'h8000, 1'b1, "ovf_sub_min");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] er;
        logic ec, ev, ez, en;
        int unsigned edges;
        model(16'h1111, 16'h2222, 1'b0, er, ec, ev, ez, en);
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0] = 16'h1111;
        b[0] = 16'h2222;
        a_s[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        edges = 1;
        while (out_valid[0] !== 1'b1 && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = (i == 3 || i == 4);
            a[0] = 16'hAAAA;
            b[0] = 16'h5555;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || sum[0] !== er || c_out[0] !== ec) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b sum=%h c=%b exp ov=1 ir=0 sum=%h c=%b",
                         i, out_valid[0], in_ready[0], sum[0], c_out[0], er, ec);
            end
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", in_ready[0], out_valid[0]);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || sum[0] !== er) begin
            errors++;
            $display("FAIL bp_not_queued got ov=%b sum=%h exp ov=0 sum=%h", out_valid[0], sum[0], er);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0] = 16'h0005;
        b[0] = 16'h0006;
        a_s[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || sum[0] !== 16'h0000 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run got ov=%b sum=%h ir=%b exp ov=0 sum=0000 ir=1",
                     out_valid[0], sum[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_partial got ov=%b exp 0", out_valid[0]);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, "after_reset");
    endtask

    task automatic test_sweep();
        for (int unsigned k = 0; k < NI; k++) begin
            for (int unsigned i = 0; i < 1000; i++) begin
                run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "sweep");
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
